// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the sequential add/sub datapath
package alu_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational ripple adder for one slice, exposing the carry into its MSB
module addsub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [SLICE:0] w_c;
  assign w_c[0] = cin;
  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign cout = w_c[SLICE];
  assign cmsb = w_c[SLICE-1];
endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/subtract, SLICE bits per clock LSB first, with start/done handshake
module addsub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Zlow,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / SLICE;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a, r_b, r_part, w_full;
  logic             r_carry;
  logic [SLICE-1:0] w_sum;
  logic             w_cout, w_cmsb, w_last;
  assign w_last = r_idx == IW'(N - 1);
  assign busy   = r_state == RUN;
  assign done   = r_state == DONE;
  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a    (r_a[r_idx*SLICE +: SLICE]),
    .b    (r_b[r_idx*SLICE +: SLICE]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout),
    .cmsb (w_cmsb)
  );
  always_comb begin
    w_full = r_part;
    w_full[r_idx*SLICE +: SLICE] = w_sum;
  end
  // subtract is folded into the operand register as ~B with carry-in 1
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_part   <= '0;
      r_carry  <= 1'b0;
      Zlow     <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_part  <= w_full;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            Zlow     <= w_full;
            c_out    <= w_cout;
            overflow <= w_cmsb ^ w_cout;
            zero     <= w_full == '0;
            r_idx    <= '0;
            r_state  <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
          if (start) begin
            r_a     <= RA;
            r_b     <= op == OP_SUB ? ~RB : RB;
            r_carry <= op == OP_SUB;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle add/subtract unit that generalises the 32-bit subtractor into one datapath block.
- Supports run-time add/sub select, configurable operand width and slice width, and a start/done handshake.
- Processes the operands SLICE bits per clock, LSB slice first, with a registered carry chain between slices.
- Sits beside the ALU and produces Zlow plus carry, overflow and zero flags for the Z register and condition logic.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle. 1 <= SLICE <= WIDTH.
- N, WIDTH/SLICE, number of slice cycles. Derived locally; not overridable.

Ports:
- clock  in  1  system clock; rising edge active.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only when not busy.
- op  in  1  operation select: 0 = add (RA+RB), 1 = subtract (RA-RB).
- RA  in  WIDTH  operand A (augend/minuend).
- RB  in  WIDTH  operand B (addend/subtrahend).
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse: result and flags are valid.
- Zlow  out  WIDTH  result, held until the next completion.
- c_out  out  1  carry out of the MSB. For subtract, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  high when Zlow == 0.

Behaviour:
- Reset (clear=0, asynchronous):
  - State goes to IDLE; slice index = 0.
  - busy, done, Zlow, c_out, overflow and zero are all 0.
  - Internal operand, carry and partial-result registers are all 0.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge E:
  - RA, RB and op are latched.
  - Carry register := op. Subtract is A + ~B + 1; ~B is formed at latch time when op=1.
  - Slice index := 0; next state RUN.
- DONE with start=0: next state IDLE. done is high only during the DONE cycle.
- RUN:
  - Each edge adds slice[idx] of A and (B or ~B) with the carry register.
  - The slice sum is written into the partial-result register at bits idx*SLICE..idx*SLICE+SLICE-1.
  - Carry register := slice carry out; idx increments.
  - On the edge that processes slice N-1:
    - Zlow := full partial result including that last slice.
    - c_out := final carry.
    - overflow := carry into MSB XOR carry out of MSB.
    - zero := (final result == 0).
    - Next state DONE.
- Latency: start sampled at edge E gives done=1 in the cycle after edge E+N (N=4 for the defaults). Back-to-back operations complete every N+1 cycles.
- busy is high in every RUN cycle and low in IDLE and DONE. start while busy is ignored and has no side effects.
- Between completions, Zlow and the flags hold their last values. Input changes after latching do not affect the operation in flight.
- A start in the DONE cycle is accepted: the done pulse is still 1 in that cycle, and the next operation begins.
- clear asserted mid-operation aborts it: all outputs return to 0 immediately; no done is issued.
- WIDTH == SLICE (N=1): behaves as a single-cycle RUN; latency is 1 edge.
- Result wraps modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package alu_pkg:
  - op encodings OP_ADD=1'b0 and OP_SUB=1'b1.
  - state encoding (IDLE/RUN/DONE, 2 bits).
  - WIDTH default constant.
- One sub-module, addsub_slice, with inputs a[SLICE], b[SLICE], cin.
  - Outputs: sum[SLICE], cout, and cmsb, the carry into its own MSB.
  - Purely combinational ripple adder. The top block uses cmsb from the last slice for overflow.
- The top block holds the FSM, index counter, operand/carry/result registers and flag logic.

Test Plan:
- Reset: hold clear=0 with start=1 and random operands -> all outputs 0, busy never rises. Release clear -> IDLE, outputs still 0.
- Sub positive: RA=5, RB=3, op=1, pulse start -> busy for 4 cycles, done after edge E+4, Zlow=0x00000002, c_out=1, overflow=0, zero=0.
- Sub borrow: RA=3, RB=5, op=1 -> Zlow=0xFFFFFFFE, c_out=0, overflow=0.
- Overflow/carry, add 0x7FFFFFFF+0x00000001 -> Zlow=0x80000000, overflow=1, c_out=0.
- Overflow/carry, sub 0x80000000-0x00000001 -> Zlow=0x7FFFFFFF, overflow=1, c_out=1.
- Overflow/carry, add 0xFFFFFFFF+0x00000001 -> Zlow=0, zero=1, c_out=1, overflow=0.
- Inter-slice carry and handshake: add 0x00FFFFFF+1 -> 0x01000000.
  - Pulse start with new operands during RUN -> ignored, result unchanged.
  - Assert start in the DONE cycle -> second op accepted, done pulses again N+1 cycles later.
- Mid-op reset and params: assert clear during RUN idx=2 -> outputs 0 at once, no done. Repeat the sub vectors with WIDTH=16, SLICE=4 and WIDTH=SLICE=8 -> correct values with latency 4 and 1.
